// File: rtl/ysyx_23060187_multicycle_ctrl.sv
// Multi-cycle sequencer: fetch/exec/mem/wb handshakes,
// per-class enable gating, sticky halt on ebreak/illegal/timeout.
module ysyx_23060187_multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        is_ebreak,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  output logic        dmem_req_valid,
  output logic        dmem_req_wr,
  input  logic        dmem_req_ready,
  input  logic        dmem_resp_valid,
  output logic        inst_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_I,
    S_EXEC,
    S_MEM,
    S_WAIT_D,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_ALU,
    C_BRANCH,
    C_LOAD,
    C_STORE
  } cls_t;

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_cls;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_err_ill;
  logic             r_err_to;
  logic [31:0]      r_instret;
  logic             w_set_ill;
  logic             w_set_to;

  logic w_ld;
  logic w_st;
  logic w_br;
  logic w_alu;
  logic w_ebrk;

  assign w_ld   = (opcode == 7'b0000011);
  assign w_st   = (opcode == 7'b0100011);
  assign w_br   = (opcode == 7'b1100011);
  assign w_ebrk = (opcode == 7'b1110011)
                & is_ebreak;
  assign w_alu  = (opcode == 7'b0110111)
                | (opcode == 7'b0010111)
                | (opcode == 7'b1101111)
                | (opcode == 7'b1100111)
                | (opcode == 7'b0010011)
                | (opcode == 7'b0110011);

  always_comb begin
    w_next    = r_state;
    w_cls     = r_cls;
    w_cnt     = r_cnt;
    w_set_ill = 1'b0;
    w_set_to  = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (imem_req_ready) begin
          w_next = S_WAIT_I;
          w_cnt  = '0;
        end
      end
      S_WAIT_I: begin
        // a response in the final cycle still wins
        if (imem_resp_valid) begin
          w_next = S_EXEC;
        end else if (r_cnt == TMO_LAST) begin
          w_next   = S_HALT;
          w_set_to = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          w_ld: begin
            w_next = S_MEM;
            w_cls  = C_LOAD;
          end
          w_st: begin
            w_next = S_MEM;
            w_cls  = C_STORE;
          end
          w_br: begin
            w_next = S_WB;
            w_cls  = C_BRANCH;
          end
          w_alu: begin
            w_next = S_WB;
            w_cls  = C_ALU;
          end
          w_ebrk: w_next = S_HALT;
          default: begin
            w_next    = S_HALT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_ready) begin
          w_next = S_WAIT_D;
          w_cnt  = '0;
        end
      end
      S_WAIT_D: begin
        if (dmem_resp_valid) begin
          w_next = S_WB;
        end else if (r_cnt == TMO_LAST) begin
          w_next   = S_HALT;
          w_set_to = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cls     <= C_ALU;
      r_cnt     <= '0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_cls   <= w_cls;
      r_cnt   <= w_cnt;
      if (w_set_ill) r_err_ill <= 1'b1;
      if (w_set_to)  r_err_to  <= 1'b1;
      if (r_state == S_WB) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign imem_req_valid = (r_state == S_FETCH);
  assign dmem_req_valid = (r_state == S_MEM);
  assign dmem_req_wr    = (r_state == S_MEM)
                        & (r_cls == C_STORE);
  assign inst_we        = (r_state == S_WAIT_I)
                        & imem_resp_valid;
  assign pc_we          = (r_state == S_WB);
  assign rf_we          = (r_state == S_WB)
                        & (r_cls != C_STORE)
                        & (r_cls != C_BRANCH);
  assign halt           = (r_state == S_HALT);
  assign err_illegal    = r_err_ill;
  assign err_timeout    = r_err_to;
  assign instret        = r_instret;

endmodule

// File: tb/tb_ysyx_23060187_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer with a
// reactive memory model and an outcome scoreboard.
module tb_ysyx_23060187_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        is_ebreak;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic        dmem_req_valid;
  logic        dmem_req_wr;
  logic        dmem_req_ready;
  logic        dmem_resp_valid;
  logic        inst_we;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic        err_illegal;
  logic        err_timeout;
  logic [31:0] instret;

  ysyx_23060187_multicycle_ctrl #(
    .TIMEOUT(255),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .is_ebreak(is_ebreak),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_wr(dmem_req_wr),
    .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .inst_we(inst_we),
    .rf_we(rf_we),
    .pc_we(pc_we),
    .halt(halt),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rf;
    logic hlt;
    logic ill;
    logic tmo;
  } exp_t;

  exp_t        sb[$];
  int          nchk;
  int          nerr;
  logic [31:0] exp_instret;

  int   o_cyc;
  int   o_pre;
  int   o_iwe_c;
  int   o_iwe_n;
  int   o_rf_n;
  int   o_pc_n;
  int   o_dreq_n;
  logic o_wr;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_FNC  = 7'b0001111;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
  endtask

  function automatic logic [31:0] ctl_vec();
    return {23'd0, imem_req_valid, dmem_req_valid,
            dmem_req_wr, inst_we, rf_we, pc_we,
            halt, err_illegal, err_timeout};
  endfunction

  task automatic rst_assert();
    rst = 1'b0;
    clr_in();
    #1;
    chk("async_rst_ctl", ctl_vec(), 32'd0);
    chk("async_rst_instret", instret, 32'd0);
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_in();
    exp_instret = 32'd0;
    #1;
    chk("idle_after_rst", ctl_vec(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_assert();
    rst_release();
  endtask

  // Memory model reacts to the request outputs; irsp/drsp
  // of -1 mean the memory never answers.
  task automatic run_inst(input logic [6:0] op,
                          input logic eb,
                          input int ir_dly,
                          input int irsp,
                          input int dr_dly,
                          input int drsp,
                          input int abort_at,
                          input logic early);
    int   c;
    int   fcnt;
    int   dcnt;
    int   ik;
    int   dk;
    logic in_wi;
    logic in_wd;
    logic done;
    exp_t e;
    c = 0; fcnt = 0; dcnt = 0; ik = 0; dk = 0;
    in_wi = 0; in_wd = 0; done = 0;
    o_cyc = 0; o_pre = 0; o_iwe_c = 0; o_iwe_n = 0;
    o_rf_n = 0; o_pc_n = 0; o_dreq_n = 0; o_wr = 0;
    for (int n = 0; n < 700 && !done; n++) begin
      @(posedge clk);
      #1;
      clr_in();
      if (imem_req_valid) begin
        imem_req_ready = (fcnt >= ir_dly);
        if (early && imem_req_ready)
          imem_resp_valid = 1'b1;
      end
      if (in_wi && irsp >= 0 && ik == irsp) begin
        imem_resp_valid = 1'b1;
        opcode          = op;
        is_ebreak       = eb;
      end
      if (dmem_req_valid)
        dmem_req_ready = (dcnt >= dr_dly);
      if (in_wd && drsp >= 0 && dk == drsp)
        dmem_resp_valid = 1'b1;
      #1;
      if (c == 0 && !imem_req_valid) o_pre++;
      else c++;
      if (c == 1 && fcnt == 0)
        chk("instret_at_fetch", instret, exp_instret);
      if (inst_we) begin
        o_iwe_n++;
        o_iwe_c = c;
      end
      o_rf_n += int'(rf_we);
      o_pc_n += int'(pc_we);
      if (dmem_req_valid) begin
        o_dreq_n++;
        o_wr = o_wr | dmem_req_wr;
      end
      if (in_wi) begin
        if (imem_resp_valid) in_wi = 0;
        else ik++;
      end
      if (imem_req_valid) begin
        if (imem_req_ready) begin
          in_wi = 1;
          ik    = 0;
        end else fcnt++;
      end
      if (in_wd) begin
        if (dmem_resp_valid) in_wd = 0;
        else dk++;
      end
      if (dmem_req_valid) begin
        if (dmem_req_ready) begin
          in_wd = 1;
          dk    = 0;
        end else dcnt++;
      end
      o_cyc = c;
      if (abort_at > 0 && c == abort_at) begin
        rst_assert();
        done = 1;
      end else if (pc_we || halt) begin
        done = 1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_rf_we", 32'(rf_we), 32'(e.rf));
          chk("sb_halt", 32'(halt), 32'(e.hlt));
          chk("sb_err_ill", 32'(err_illegal),
              32'(e.ill));
          chk("sb_err_to", 32'(err_timeout),
              32'(e.tmo));
        end
        if (pc_we) exp_instret = exp_instret + 32'd1;
      end
    end
    if (!done)
      chk("cycle_budget", 32'd0, 32'd1);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    exp_instret = 32'd0;
    rst = 1'b0;
    opcode = 7'd0;
    is_ebreak = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_vec(), 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst_release();

    // addi, zero-wait imem
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_ADDI, 0, 0, 0, 0, 0, 0, 0);
    chk("addi_cycles", o_cyc, 4);
    chk("addi_iwe_cyc", o_iwe_c, 2);
    chk("addi_iwe_n", o_iwe_n, 1);
    chk("addi_pre", o_pre, 0);

    // lui with slow imem handshake and response
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_LUI, 0, 2, 3, 0, 0, 0, 0);
    chk("lui_cycles", o_cyc, 9);
    chk("lui_iwe_cyc", o_iwe_c, 7);

    // load with dmem_req_ready low for 3 cycles
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_LD, 0, 0, 0, 3, 0, 0, 0);
    chk("ld_cycles", o_cyc, 9);
    chk("ld_dreq_n", o_dreq_n, 4);
    chk("ld_wr", 32'(o_wr), 0);
    chk("ld_rf_n", o_rf_n, 1);

    sb.push_back('{rf:0, hlt:0, ill:0, tmo:0});
    run_inst(OP_ST, 0, 0, 0, 0, 0, 0, 0);
    chk("st_cycles", o_cyc, 6);
    chk("st_wr", 32'(o_wr), 1);
    chk("st_rf_n", o_rf_n, 0);
    chk("st_pc_n", o_pc_n, 1);

    sb.push_back('{rf:0, hlt:0, ill:0, tmo:0});
    run_inst(OP_BR, 0, 0, 0, 0, 0, 0, 0);
    chk("br_cycles", o_cyc, 4);
    chk("br_rf_n", o_rf_n, 0);
    chk("br_pc_n", o_pc_n, 1);

    // response during the fetch handshake is ignored
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_JAL, 0, 0, 1, 0, 0, 0, 1);
    chk("early_cycles", o_cyc, 5);
    chk("early_iwe_cyc", o_iwe_c, 3);
    chk("early_iwe_n", o_iwe_n, 1);

    // fence is unsupported
    sb.push_back('{rf:0, hlt:1, ill:1, tmo:0});
    run_inst(OP_FNC, 0, 0, 0, 0, 0, 0, 0);
    chk("ill_cycles", o_cyc, 4);
    chk("ill_pc_n", o_pc_n, 0);
    repeat (3) @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    #1;
    chk("halt_sticky", ctl_vec(), 32'h0000_0006);
    chk("halt_instret", instret, 32'd6);
    do_reset();

    // ecall is a system op without ebreak
    sb.push_back('{rf:0, hlt:1, ill:1, tmo:0});
    run_inst(OP_SYS, 0, 0, 0, 0, 0, 0, 0);
    chk("ecall_pc_n", o_pc_n, 0);
    do_reset();

    sb.push_back('{rf:0, hlt:1, ill:0, tmo:0});
    run_inst(OP_SYS, 1, 0, 0, 0, 0, 0, 0);
    chk("ebreak_cycles", o_cyc, 4);
    do_reset();

    // imem never answers
    sb.push_back('{rf:0, hlt:1, ill:0, tmo:1});
    run_inst(OP_ADDI, 0, 0, -1, 0, 0, 0, 0);
    chk("tmo_cycles", o_cyc, 257);
    chk("tmo_iwe_n", o_iwe_n, 0);
    do_reset();

    // answer in the last allowed cycle
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_ADDI, 0, 0, 254, 0, 0, 0, 0);
    chk("tmo_edge_cycles", o_cyc, 258);
    chk("tmo_edge_iwe", o_iwe_c, 256);

    // reset while waiting on a load
    run_inst(OP_LD, 0, 0, 0, 0, -1, 6, 0);
    chk("abort_cycle", o_cyc, 6);
    chk("abort_pc_n", o_pc_n, 0);
    rst_release();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    sb.push_back('{rf:1, hlt:0, ill:0, tmo:0});
    run_inst(OP_ADDI, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_pre", o_pre, 0);
    chk("post_rst_cycles", o_cyc, 4);
    chk("post_rst_rf_n", o_rf_n, 1);
    @(posedge clk);
    #2;
    chk("instret_wrap", instret, exp_instret);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
